// File: rtl/fx_host_master_if.sv
// fx host master bundle: host byte link (rx/tx) plus the fx register bus.
// The master modport is the initiator side; slave is the host/responder side.
interface fx_host_master_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic        busy;
    logic        err;

    modport master (
        input  rx_data, rx_vld, tx_rdy, fx_q,
        output tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd, busy, err
    );

    modport slave (
        output rx_data, rx_vld, tx_rdy, fx_q,
        input  tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd, busy, err
    );
endinterface

// File: rtl/fx_host_master.sv
// fx host master: parses host frames (cmd, 3 address bytes, count, data)
// into fx write/read cycles with 22-bit address auto-increment, and returns
// read bytes on a valid/ready stream. One read outstanding at a time.
module fx_host_master #(
    parameter int unsigned RD_LAT  = 2,        // fx_rd pulse -> fx_q sample cycle (1..7)
    parameter logic [15:0] TIMEOUT = 16'd50000 // idle cycles allowed between frame bytes
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    fx_host_master_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, A2, A1, A0, LEN, WDAT, RISS, RWAIT, RSEND
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    state_t      state, state_nxt;
    logic        is_rd;
    logic [21:0] addr, addr_nxt;
    logic [8:0]  cnt, cnt_nxt;
    logic [15:0] gap;
    logic [RD_LAT:1] vld_pipe;

    // control strobes from the next-state logic
    logic ld_cmd, wr_go, samp, accept, tmo, drop, timed;

    // registered outputs
    logic [7:0]  tx_data_q;
    logic        tx_vld_q;
    logic [21:0] fx_waddr_q;
    logic        fx_wr_q;
    logic [7:0]  fx_data_q;
    logic [21:0] fx_raddr_q;
    logic        fx_rd_q;
    logic        err_q;

    wire       rx = bus.rx_vld;
    wire [7:0] b  = bus.rx_data;

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_vld   = tx_vld_q;
    assign bus.fx_waddr = fx_waddr_q;
    assign bus.fx_wr    = fx_wr_q;
    assign bus.fx_data  = fx_data_q;
    assign bus.fx_raddr = fx_raddr_q;
    assign bus.fx_rd    = fx_rd_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state != IDLE);

    // Only the frame-receiving states are guarded by the gap timer; the read
    // states wait on the responder and the host and may stall indefinitely.
    assign timed = (state inside {A2, A1, A0, LEN, WDAT});

    // FSM state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, address/count update and per-cycle strobes
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        ld_cmd    = 1'b0;
        wr_go     = 1'b0;
        samp      = 1'b0;
        accept    = 1'b0;
        tmo       = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                // Non-command bytes between frames are silently discarded.
                if (rx && (b == CMD_WR || b == CMD_RD)) begin
                    ld_cmd    = 1'b1;
                    state_nxt = A2;
                end
            end
            A2: if (rx) begin
                addr_nxt[21:16] = b[5:0];
                state_nxt       = A1;
            end
            A1: if (rx) begin
                addr_nxt[15:8] = b;
                state_nxt      = A0;
            end
            A0: if (rx) begin
                addr_nxt[7:0] = b;
                state_nxt     = LEN;
            end
            LEN: if (rx) begin
                cnt_nxt   = (b == 8'd0) ? 9'd256 : {1'b0, b};
                state_nxt = is_rd ? RISS : WDAT;
            end
            WDAT: if (rx) begin
                wr_go     = 1'b1;
                addr_nxt  = addr + 22'd1;
                cnt_nxt   = cnt - 9'd1;
                if (cnt == 9'd1) state_nxt = IDLE;
            end
            RISS: state_nxt = RWAIT;
            RWAIT: if (vld_pipe[RD_LAT]) begin
                samp      = 1'b1;
                state_nxt = RSEND;
            end
            RSEND: if (tx_vld_q && bus.tx_rdy) begin
                accept    = 1'b1;
                addr_nxt  = addr + 22'd1;
                cnt_nxt   = cnt - 9'd1;
                state_nxt = (cnt == 9'd1) ? IDLE : RISS;
            end
            default: state_nxt = IDLE;
        endcase
        // A byte arriving in the expiry cycle keeps the frame alive.
        if (timed && !rx && gap == TIMEOUT - 16'd1) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
        end
        // Host must not push bytes while a read is in flight.
        if (rx && (state inside {RISS, RWAIT, RSEND})) drop = 1'b1;
    end

    // Frame context: command type, address, remaining count, gap timer
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            is_rd <= 1'b0;
            addr  <= '0;
            cnt   <= '0;
            gap   <= '0;
        end else begin
            if (ld_cmd) is_rd <= (b == CMD_RD);
            addr <= addr_nxt;
            cnt  <= cnt_nxt;
            if (rx || !timed || state_nxt != state) gap <= '0;
            else                                    gap <= gap + 16'd1;
        end
    end

    // fx bus strobes; address/data hold between strobes
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_wr_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_data_q  <= '0;
            fx_rd_q    <= 1'b0;
            fx_raddr_q <= '0;
        end else begin
            fx_wr_q <= wr_go;
            if (wr_go) begin
                fx_waddr_q <= addr;
                fx_data_q  <= b;
            end
            // RISS lasts exactly one cycle, so fx_rd is high exactly in RISS.
            fx_rd_q <= (state_nxt == RISS);
            if (state_nxt == RISS) fx_raddr_q <= addr_nxt;
        end
    end

    // Read latency tracker: vld_pipe[k] is high k cycles after the fx_rd pulse
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= fx_rd_q;
            for (int i = 2; i <= int'(RD_LAT); i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Host return byte: capture fx_q, hold until accepted
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else if (samp) begin
            tx_data_q <= bus.fx_q;
            tx_vld_q  <= 1'b1;
        end else if (accept) begin
            tx_vld_q  <= 1'b0;
        end
    end

    // Error pulse for dropped bytes and frame timeouts
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= drop | tmo;
    end

endmodule

// File: tb/tb_fx_host_master.sv
// Directed bench for fx_host_master: table-driven write frames plus
// hand-written read, backpressure, count-0, timeout and reset sequences.
module tb_fx_host_master;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    fx_host_master_if bus();

    fx_host_master #(.RD_LAT(2), .TIMEOUT(16'd100)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Responder model: returns the low address byte RD_LAT=2 cycles after fx_rd,
    // drives 0 otherwise (OR-ed responder bus).
    logic [7:0] rsp1 = 8'h00, rsp2 = 8'h00;
    always @(posedge clk_sys) begin
        rsp1 <= bus.fx_rd ? bus.fx_raddr[7:0] : 8'h00;
        rsp2 <= rsp1;
    end
    assign bus.fx_q = rsp2;

    // Strobe monitors
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    always @(posedge clk_sys) begin
        if (bus.fx_wr) wr_cnt <= wr_cnt + 1;
        if (bus.fx_rd) rd_cnt <= rd_cnt + 1;
        if (bus.fx_wr && bus.fx_rd) both_cnt <= both_cnt + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        bus.rx_data = v;
        bus.rx_vld  = 1'b1;
        tick();
        bus.rx_vld  = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  rx;
        logic        wr;
        logic [21:0] wa;
        logic [7:0]  wd;
        logic        busy;
    } vec_t;

    vec_t vt[15];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base, bad, k, got, r0;

        vt[0]  = '{8'h11, 1'b0, 22'h000000, 8'h00, 1'b0};
        vt[1]  = '{8'h57, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[2]  = '{8'h00, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[3]  = '{8'h12, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[4]  = '{8'h34, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[5]  = '{8'h02, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[6]  = '{8'hAA, 1'b1, 22'h001234, 8'hAA, 1'b1};
        vt[7]  = '{8'hBB, 1'b1, 22'h001235, 8'hBB, 1'b0};
        vt[8]  = '{8'h57, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[9]  = '{8'hFF, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[10] = '{8'hFF, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[11] = '{8'hFF, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[12] = '{8'h02, 1'b0, 22'h000000, 8'h00, 1'b1};
        vt[13] = '{8'h01, 1'b1, 22'h3FFFFF, 8'h01, 1'b1};
        vt[14] = '{8'h02, 1'b1, 22'h000000, 8'h02, 1'b0};

        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        bus.tx_rdy  = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_busy",   32'(bus.busy),   0);
        chk("rst_fx_wr",  32'(bus.fx_wr),  0);
        chk("rst_fx_rd",  32'(bus.fx_rd),  0);
        chk("rst_tx_vld", 32'(bus.tx_vld), 0);
        chk("rst_err",    32'(bus.err),    0);
        rst_n = 1'b1;
        tick();

        // write frames, incl. ignored stray byte and 0x3FFFFF wrap
        for (int i = 0; i < 15; i++) begin
            send(vt[i].rx);
            chk($sformatf("vec%0d_wr", i), 32'(bus.fx_wr), 32'(vt[i].wr));
            if (vt[i].wr) begin
                chk($sformatf("vec%0d_waddr", i), 32'(bus.fx_waddr), 32'(vt[i].wa));
                chk($sformatf("vec%0d_wdata", i), 32'(bus.fx_data),  32'(vt[i].wd));
            end
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
            chk($sformatf("vec%0d_err", i),  32'(bus.err),  0);
        end
        tick();

        // read burst with wrap, backpressure and a dropped byte
        send(8'h52); send(8'h3F); send(8'hFF); send(8'hFF); send(8'h02);
        chk("rd0_fx_rd",  32'(bus.fx_rd),    1);
        chk("rd0_raddr",  32'(bus.fx_raddr), 32'h3FFFFF);
        tick();
        chk("rd0_pulse_len", 32'(bus.fx_rd), 0);
        tick();
        chk("rd0_early_vld", 32'(bus.tx_vld), 0);
        tick();
        chk("rd0_tx_vld",  32'(bus.tx_vld),  1);
        chk("rd0_tx_data", 32'(bus.tx_data), 32'hFF);
        r0  = rd_cnt;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send(8'h33);
            else        tick();
            if (i == 5) chk("drop_err_pulse", 32'(bus.err), 1);
            if (i == 6) chk("drop_err_clear", 32'(bus.err), 0);
            if (!bus.tx_vld || bus.tx_data !== 8'hFF) bad++;
        end
        chk("bp_stable",     32'(bad), 0);
        chk("bp_no_2nd_rd",  32'(rd_cnt - r0), 0);
        chk("bp_busy",       32'(bus.busy), 1);
        bus.tx_rdy = 1'b1;
        tick();
        chk("rd1_accept_vld", 32'(bus.tx_vld),   0);
        chk("rd1_fx_rd",      32'(bus.fx_rd),    1);
        chk("rd1_raddr_wrap", 32'(bus.fx_raddr), 32'h000000);
        repeat (3) tick();
        chk("rd1_tx_vld",  32'(bus.tx_vld),  1);
        chk("rd1_tx_data", 32'(bus.tx_data), 32'h00);
        tick();
        chk("rd1_done_vld",  32'(bus.tx_vld), 0);
        chk("rd1_done_busy", 32'(bus.busy),   0);
        chk("rd_total",      32'(rd_cnt - r0 + 1), 2);
        bus.tx_rdy = 1'b0;

        // count 0 encodes 256 writes
        base = wr_cnt;
        send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            if (!bus.fx_wr || bus.fx_waddr !== 22'(i) || bus.fx_data !== 8'(i)) bad++;
        end
        chk("cnt0_seq",  32'(bad),      0);
        chk("cnt0_busy", 32'(bus.busy), 0);
        repeat (3) tick();
        chk("cnt0_total", 32'(wr_cnt - base), 256);

        // timeout after 100 silent cycles
        base = wr_cnt;
        send(8'h57); send(8'h00); send(8'h00);
        k = 0; got = 0;
        while (k < 200 && got == 0) begin
            tick();
            k++;
            if (bus.err) got = 1;
        end
        chk("tmo_seen",   32'(got), 1);
        chk("tmo_cycles", 32'(k),   100);
        chk("tmo_busy",   32'(bus.busy), 0);
        tick();
        chk("tmo_err_1cyc", 32'(bus.err), 0);
        chk("tmo_no_wr",    32'(wr_cnt - base), 0);
        send(8'h11);
        chk("stray_busy", 32'(bus.busy), 0);
        chk("stray_err",  32'(bus.err),  0);
        bus.tx_rdy = 1'b1;
        send(8'h52); send(8'h00); send(8'h00); send(8'h07); send(8'h01);
        k = 0; got = 0;
        while (k < 20 && got == 0) begin
            if (bus.tx_vld) got = 1;
            else begin tick(); k++; end
        end
        chk("post_tmo_rd_seen", 32'(got), 1);
        chk("post_tmo_rd_data", 32'(bus.tx_data), 32'h07);
        tick();
        chk("post_tmo_rd_busy", 32'(bus.busy), 0);
        bus.tx_rdy = 1'b0;

        // asynchronous reset while a read byte is pending
        send(8'h52); send(8'h00); send(8'h00); send(8'h42); send(8'h01);
        repeat (3) tick();
        chk("rrst_pre_vld",  32'(bus.tx_vld),  1);
        chk("rrst_pre_data", 32'(bus.tx_data), 32'h42);
        #2 rst_n = 1'b0;
        #1;
        chk("rrst_tx_vld",  32'(bus.tx_vld),   0);
        chk("rrst_tx_data", 32'(bus.tx_data),  0);
        chk("rrst_busy",    32'(bus.busy),     0);
        chk("rrst_raddr",   32'(bus.fx_raddr), 0);
        chk("rrst_waddr",   32'(bus.fx_waddr), 0);
        chk("rrst_wdata",   32'(bus.fx_data),  0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        send(8'h57); send(8'h00); send(8'h00); send(8'h05); send(8'h01); send(8'h9C);
        chk("fresh_wr",    32'(bus.fx_wr),    1);
        chk("fresh_waddr", 32'(bus.fx_waddr), 32'h000005);
        chk("fresh_wdata", 32'(bus.fx_data),  32'h9C);
        chk("fresh_busy",  32'(bus.busy),     0);
        tick();
        chk("wr_rd_exclusive", 32'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_host_master.md
Name: fx_host_master

Overview:
- Initiator end of the fx register bus: converts a host byte stream (from the UART/USB byte link) into fx write and read cycles.
- Returns read data bytes to the host on a valid/ready byte stream.
- Sits between the host link and the per-block register files (para regs etc.), which are fx responders.
- Supports burst access with 22-bit address auto-increment.

Parameters:
- RD_LAT, 2: cycles from the fx_rd pulse to the cycle in which fx_q is sampled (1..7).
- TIMEOUT, 16'd50000: idle clk_sys cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  host command byte
- rx_vld  in  1  one-cycle strobe; rx_data valid
- tx_data  out  8  read data byte to host
- tx_vld  out  1  tx_data valid; held until accepted
- tx_rdy  in  1  host link accepts tx_data when tx_vld && tx_rdy
- fx_waddr  out  22  write address
- fx_wr  out  1  one-cycle write strobe
- fx_data  out  8  write data
- fx_raddr  out  22  read address
- fx_rd  out  1  one-cycle read strobe
- fx_q  in  8  read data from the OR-ed responders
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on a dropped byte or a timeout

Behaviour:
- Clock and reset: one clock, clk_sys; rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; address and counters 0. Asserting reset mid-frame aborts the frame and drops any pending tx byte.
- Frame format:
  - Byte 0 is the command: 0x57 = write, 0x52 = read.
  - Bytes 1-3 are the address, MSB first; bits [7:6] of byte 1 are ignored.
  - Byte 4 is the count N; 0 encodes 256.
  - A write frame then carries N data bytes. A read frame carries no further bytes.
- FSM states: IDLE, A2, A1, A0, LEN, WDAT, RISS, RWAIT, RSEND.
  - IDLE: rx_vld with a valid command -> A2, command latched. Any other byte is ignored; no err.
  - A2 -> A1 -> A0 -> LEN: each transition happens on rx_vld, loading addr[21:16], [15:8], [7:0] respectively.
  - LEN: on rx_vld, load cnt = (byte == 0) ? 256 : byte (9-bit). Go to WDAT if write, RISS if read.
  - WDAT: on rx_vld, the next cycle has fx_wr=1, fx_waddr=addr, fx_data=byte. Then addr++ and cnt--. When cnt reaches 0 -> IDLE.
  - RISS: fx_rd=1 for one cycle with fx_raddr=addr -> RWAIT.
  - RWAIT: count RD_LAT cycles after the pulse and sample fx_q into tx_data on the RD_LAT-th cycle. In that same cycle set tx_vld=1 -> RSEND.
  - RSEND: hold tx_data/tx_vld until tx_rdy. In the accept cycle, clear tx_vld, addr++, cnt--. Then go to RISS if cnt != 0, else IDLE.
- Address arithmetic: 22-bit increment; 0x3FFFFF wraps to 0x000000 with no error.
- fx_waddr/fx_data and fx_raddr hold their last values between strobes. fx_wr and fx_rd are never high in the same cycle.
- Write throughput: one fx_wr per received byte, latency 1 cycle from rx_vld. Back-to-back rx_vld on consecutive cycles is supported.
- Read throughput: at most one byte per RD_LAT+2 cycles; there is no read pipelining.
- rx_vld while in RISS, RWAIT or RSEND: byte dropped, err pulses for 1 cycle, FSM unaffected.
- Timeout:
  - Applies in A2..LEN and WDAT. A 16-bit gap counter clears on every rx_vld and on state entry.
  - When it reaches TIMEOUT -> IDLE, err pulse, no fx strobe.
  - Read states never time out; a host holding tx_rdy low stalls RSEND indefinitely.
- Simultaneous events: a timeout and rx_vld in the same cycle -> rx_vld wins and the counter clears.

Test Plan:
- Write burst: bytes 57 00 12 34 02 AA BB on consecutive cycles -> fx_wr pulses at 0x001234/AA and 0x001235/BB, each 1 cycle after its rx_vld; then busy=0.
- Read burst, RD_LAT=2, responder model returning low address byte: 52 3F FF FF 02 -> fx_rd at 0x3FFFFF, tx byte FF; fx_rd at 0x000000 (wrap), tx byte 00.
- Backpressure: tx_rdy held low 20 cycles during a read -> tx_vld and tx_data stay stable, no second fx_rd until accept. Same run: an rx byte sent during RSEND -> err pulse, frame completes normally.
- Count 0: 57 00 00 00 00 followed by 256 data bytes -> exactly 256 fx_wr at addresses 0x000000..0x0000FF, then IDLE.
- Timeout, TIMEOUT=100: 57 00 00 then silence -> after 100 cycles err pulse, state IDLE, no fx_wr. A following 0x11 byte is ignored; a following 52 frame executes correctly.
- Reset mid-read: assert rst_n low while tx_vld=1 -> all outputs 0 immediately (asynchronous); after release, IDLE and a fresh frame works.
